// File: rtl/neureka_infeat_buffer_mbist.sv
// Input-feature buffer exposing every word in parallel, with an on-chip March C- self-test.
// While the engine is busy it owns the array and all functional strobes are ignored.
module neureka_infeat_buffer_mbist #(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_WORDS  = 64,
    parameter int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            clear_i,
    input  logic                            re_i,
    input  logic [ADDR_WIDTH-1:0]           raddr_i,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    output logic                            rvalid_o,
    input  logic                            we_i,
    input  logic                            we_all_i,
    input  logic [ADDR_WIDTH-1:0]           waddr_i,
    input  logic [DATA_WIDTH-1:0]           wdata_i,
    output logic [NUM_WORDS*DATA_WIDTH-1:0] infeat_buffer_o,
    input  logic                            bist_start_i,
    output logic                            bist_busy_o,
    output logic                            bist_done_o,
    output logic                            bist_fail_o,
    output logic [ADDR_WIDTH-1:0]           bist_fail_addr_o,
    output logic [2:0]                      bist_state_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0, M0 = 3'd1, M1 = 3'd2, M2 = 3'd3,
        M3   = 3'd4, M4 = 3'd5, M5 = 3'd6, FIN = 3'd7
    } bist_state_e;

    localparam logic [ADDR_WIDTH:0]   NUM_WORDS_EXT = (ADDR_WIDTH+1)'(NUM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR     = ADDR_WIDTH'(NUM_WORDS - 1);

    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] mem_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    bist_state_e           state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  phase_q;
    logic                  cmp_v_q;
    logic                  cmp_ones_q;
    logic [ADDR_WIDTH-1:0] cmp_addr_q;
    logic [DATA_WIDTH-1:0] cmp_data_q;
    logic                  done_q;
    logic                  fail_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;

    logic                  idle;
    logic                  raddr_ok;
    logic                  waddr_ok;
    logic                  bist_rd;
    logic                  bist_wr;
    logic                  bist_wones;
    logic                  exp_ones;
    logic                  desc;
    logic                  step;
    logic                  at_end;
    bist_state_e           next_elem;
    logic [ADDR_WIDTH-1:0] next_start;

    // Per-element decode: M1..M4 spend phase 0 reading and phase 1 writing the same address.
    always_comb begin
        idle       = (state_q == IDLE);
        raddr_ok   = ({1'b0, raddr_i} < NUM_WORDS_EXT);
        waddr_ok   = ({1'b0, waddr_i} < NUM_WORDS_EXT);
        bist_rd    = 1'b0;
        bist_wr    = 1'b0;
        bist_wones = 1'b0;
        exp_ones   = 1'b0;
        desc       = 1'b0;
        step       = 1'b0;
        next_elem  = FIN;
        next_start = '0;
        case (state_q)
            M0: begin
                bist_wr = 1'b1; step = 1'b1; next_elem = M1;
            end
            M1: begin
                bist_rd = !phase_q; bist_wr = phase_q; step = phase_q;
                bist_wones = 1'b1; next_elem = M2;
            end
            M2: begin
                bist_rd = !phase_q; bist_wr = phase_q; step = phase_q;
                exp_ones = 1'b1; next_elem = M3; next_start = LAST_ADDR;
            end
            M3: begin
                bist_rd = !phase_q; bist_wr = phase_q; step = phase_q;
                bist_wones = 1'b1; desc = 1'b1; next_elem = M4; next_start = LAST_ADDR;
            end
            M4: begin
                bist_rd = !phase_q; bist_wr = phase_q; step = phase_q;
                exp_ones = 1'b1; desc = 1'b1; next_elem = M5;
            end
            M5: begin
                bist_rd = 1'b1; step = 1'b1; next_elem = FIN;
            end
            default: ;
        endcase
        at_end = desc ? (addr_q == '0) : (addr_q == LAST_ADDR);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= idle && re_i;
            if (idle && re_i) begin
                rdata_q <= raddr_ok ? mem_q[raddr_i] : '0;
            end
            if (idle) begin
                if (clear_i) begin
                    mem_q <= '0;
                end else if (we_all_i) begin
                    mem_q <= {NUM_WORDS{wdata_i}};
                end else if (we_i && waddr_ok) begin
                    mem_q[waddr_i] <= wdata_i;
                end
            end else if (bist_wr) begin
                mem_q[addr_q] <= {DATA_WIDTH{bist_wones}};
            end
        end
    end

    // Compare is pipelined: the word read on one edge is checked on the next, so FIN covers M5's last read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            cmp_v_q     <= 1'b0;
            cmp_ones_q  <= 1'b0;
            cmp_addr_q  <= '0;
            cmp_data_q  <= '0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
        end else begin
            cmp_v_q <= bist_rd;
            if (bist_rd) begin
                cmp_data_q <= mem_q[addr_q];
                cmp_ones_q <= exp_ones;
                cmp_addr_q <= addr_q;
            end
            if (cmp_v_q && !fail_q && (cmp_data_q != {DATA_WIDTH{cmp_ones_q}})) begin
                fail_q      <= 1'b1;
                fail_addr_q <= cmp_addr_q;
            end
            case (state_q)
                IDLE: begin
                    if (bist_start_i) begin
                        state_q     <= M0;
                        addr_q      <= '0;
                        phase_q     <= 1'b0;
                        done_q      <= 1'b0;
                        fail_q      <= 1'b0;
                        fail_addr_q <= '0;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: begin
                    if (!step) begin
                        phase_q <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        if (at_end) begin
                            state_q <= next_elem;
                            addr_q  <= next_start;
                        end else if (desc) begin
                            addr_q <= addr_q - ADDR_WIDTH'(1);
                        end else begin
                            addr_q <= addr_q + ADDR_WIDTH'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign rdata_o          = rdata_q;
    assign rvalid_o         = rvalid_q;
    assign infeat_buffer_o  = mem_q;
    assign bist_busy_o      = !idle;
    assign bist_done_o      = done_q;
    assign bist_fail_o      = fail_q;
    assign bist_fail_addr_o = fail_addr_q;
    assign bist_state_o     = state_q;

endmodule

// File: tb/tb_neureka_infeat_buffer_mbist.sv
// Directed bench for the input-feature buffer and its March C- engine at depths 64 and 48.
module tb_neureka_infeat_buffer_mbist;

    logic           clk = 1'b0;
    logic           rst;
    logic           clear, re, we, we_all, start;
    logic [5:0]     raddr, waddr;
    logic [127:0]   wdata;
    logic [127:0]   rdata;
    logic           rvalid, busy, done, fail;
    logic [5:0]     fail_addr;
    logic [2:0]     state;
    logic [8191:0]  buf64;

    logic           clear48, re48, we48, we_all48, start48;
    logic [5:0]     raddr48, waddr48;
    logic [15:0]    wdata48, rdata48;
    logic           rvalid48, busy48, done48, fail48;
    logic [5:0]     fail_addr48;
    logic [2:0]     state48;
    logic [767:0]   buf48;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    neureka_infeat_buffer_mbist #(.DATA_WIDTH(128), .NUM_WORDS(64)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .re_i(re), .raddr_i(raddr),
        .rdata_o(rdata), .rvalid_o(rvalid), .we_i(we), .we_all_i(we_all),
        .waddr_i(waddr), .wdata_i(wdata), .infeat_buffer_o(buf64),
        .bist_start_i(start), .bist_busy_o(busy), .bist_done_o(done),
        .bist_fail_o(fail), .bist_fail_addr_o(fail_addr), .bist_state_o(state)
    );

    neureka_infeat_buffer_mbist #(.DATA_WIDTH(16), .NUM_WORDS(48)) dut48 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear48), .re_i(re48), .raddr_i(raddr48),
        .rdata_o(rdata48), .rvalid_o(rvalid48), .we_i(we48), .we_all_i(we_all48),
        .waddr_i(waddr48), .wdata_i(wdata48), .infeat_buffer_o(buf48),
        .bist_start_i(start48), .bist_busy_o(busy48), .bist_done_o(done48),
        .bist_fail_o(fail48), .bist_fail_addr_o(fail_addr48), .bist_state_o(state48)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nz64();
        int n = 0;
        for (int i = 0; i < 64; i++) if (buf64[i*128 +: 128] !== 128'd0) n++;
        return n;
    endfunction

    function automatic int nz48();
        int n = 0;
        for (int i = 0; i < 48; i++) if (buf48[i*16 +: 16] !== 16'd0) n++;
        return n;
    endfunction

    // Pulses start on the 64-word instance; cycle k is the k-th falling edge after the start edge.
    task automatic run64(input bit strobe, input int rst_at,
                         output int busy_cnt, output int end_cyc, output bit rv_seen);
        busy_cnt = 0;
        end_cyc  = 0;
        rv_seen  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 2000; k++) begin
            if (rvalid) rv_seen = 1'b1;
            if (!busy) begin
                end_cyc = k;
                break;
            end
            busy_cnt++;
            if (k == rst_at) begin
                end_cyc = k;
                break;
            end
            if (strobe && k == 1) begin
                we_all = 1'b1; we = 1'b1; re = 1'b1; clear = 1'b0;
                wdata = '1; waddr = 6'd0; raddr = 6'd3; start = 1'b1;
            end
            if (k == 600) begin
                we_all = 1'b0; we = 1'b0; re = 1'b0; start = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    int busy_cnt, end_cyc, busy48_cnt, end48;
    bit rv_seen;

    initial begin
        rst = 1'b1;
        clear = 0; re = 0; we = 0; we_all = 0; start = 0;
        raddr = '0; waddr = '0; wdata = '0;
        clear48 = 0; re48 = 0; we48 = 0; we_all48 = 0; start48 = 0;
        raddr48 = '0; waddr48 = '0; wdata48 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_rdata", rdata, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_fail_addr", fail_addr, 0);
        check("rst_state", state, 0);
        check("rst_array_nz", nz64(), 0);

        // Single write then read with one-cycle latency
        we = 1'b1; waddr = 6'd3; wdata = {16{8'hA5}};
        @(negedge clk);
        we = 1'b0;
        check("wr3_visible", buf64[3*128 +: 128], {16{8'hA5}});
        re = 1'b1; raddr = 6'd3;
        @(negedge clk);
        re = 1'b0;
        check("rd3_data", rdata, {16{8'hA5}});
        check("rd3_rvalid", rvalid, 1);
        @(negedge clk);
        check("rd3_rvalid_drop", rvalid, 0);
        check("rd3_hold", rdata, {16{8'hA5}});

        // Out-of-range access on the 48-word instance
        we_all48 = 1'b1; wdata48 = 16'h1234;
        @(negedge clk);
        we_all48 = 1'b0;
        we48 = 1'b1; waddr48 = 6'd50; wdata48 = 16'hFFFF;
        re48 = 1'b1; raddr48 = 6'd48;
        @(negedge clk);
        we48 = 1'b0; re48 = 1'b0;
        check("n48_oor_read", rdata48, 0);
        check("n48_oor_rvalid", rvalid48, 1);
        check("n48_oor_write_dropped", (buf48 === {48{16'h1234}}), 1);
        clear48 = 1'b1;
        @(negedge clk);
        clear48 = 1'b0;
        check("n48_clear", nz48(), 0);

        // Write priority
        clear = 1'b1; we_all = 1'b1; we = 1'b1; waddr = 6'd3; wdata = '1;
        @(negedge clk);
        check("prio_clear_wins", nz64(), 0);
        clear = 1'b0; we_all = 1'b1; we = 1'b1; waddr = 6'd2; wdata = {4{32'hCAFE0001}};
        @(negedge clk);
        we_all = 1'b0; we = 1'b0;
        check("prio_weall_wins_w2", buf64[2*128 +: 128], {4{32'hCAFE0001}});
        check("prio_weall_w63", buf64[63*128 +: 128], {4{32'hCAFE0001}});

        // Same-cycle read and write returns old data
        we = 1'b1; waddr = 6'd7; wdata = {16{8'h11}};
        @(negedge clk);
        re = 1'b1; raddr = 6'd7; waddr = 6'd7; wdata = {16{8'h22}};
        @(negedge clk);
        re = 1'b0; we = 1'b0;
        check("rw7_old_data", rdata, {16{8'h11}});
        check("rw7_new_word", buf64[7*128 +: 128], {16{8'h22}});

        // Clean BIST with functional strobes applied mid-run
        run64(1'b1, 0, busy_cnt, end_cyc, rv_seen);
        check("clean_busy_cycles", busy_cnt, 641);
        check("clean_done_cycle", end_cyc, 642);
        check("clean_done", done, 1);
        check("clean_fail", fail, 0);
        check("clean_array_nz", nz64(), 0);
        check("clean_no_rvalid", rv_seen, 0);
        check("clean_rdata_kept", rdata, {16{8'h11}});

        // Stuck-at-1 on bit 0 of word 5
        force dut.mem_q[5][0] = 1'b1;
        run64(1'b0, 0, busy_cnt, end_cyc, rv_seen);
        release dut.mem_q[5][0];
        check("stuck_busy_cycles", busy_cnt, 641);
        check("stuck_done_cycle", end_cyc, 642);
        check("stuck_done", done, 1);
        check("stuck_fail", fail, 1);
        check("stuck_fail_addr", fail_addr, 5);

        // Reset in the middle of a run
        run64(1'b0, 200, busy_cnt, end_cyc, rv_seen);
        check("abort_reached_200", end_cyc, 200);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_fail", fail, 0);
        check("abort_fail_addr", fail_addr, 0);
        check("abort_state", state, 0);
        check("abort_array_nz", nz64(), 0);
        rst = 1'b0;
        @(negedge clk);
        run64(1'b0, 0, busy_cnt, end_cyc, rv_seen);
        check("rerun_done_cycle", end_cyc, 642);
        check("rerun_done", done, 1);
        check("rerun_fail", fail, 0);

        // Non-power-of-two depth: M3 writes address 47 first, at cycle 5N+2
        start48 = 1'b1;
        @(negedge clk);
        start48 = 1'b0;
        busy48_cnt = 0;
        end48 = 0;
        for (int k = 1; k <= 2000; k++) begin
            if (!busy48) begin
                end48 = k;
                break;
            end
            busy48_cnt++;
            if (k == 242) check("n48_w47_before_m3", buf48[47*16 +: 16], 16'h0000);
            if (k == 243) begin
                check("n48_w47_m3_first", buf48[47*16 +: 16], 16'hFFFF);
                check("n48_w46_untouched", buf48[46*16 +: 16], 16'h0000);
            end
            @(negedge clk);
        end
        check("n48_busy_cycles", busy48_cnt, 481);
        check("n48_done_cycle", end48, 482);
        check("n48_done", done48, 1);
        check("n48_fail", fail48, 0);
        check("n48_array_nz", nz48(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neureka_infeat_buffer_mbist.md
# neureka_infeat_buffer_mbist

Parametrised input-feature buffer with a built-in March C- self-test engine. It replaces an externally driven test-port mux with an on-chip controller that runs a complete memory test from a single start pulse and reports pass/fail plus the first failing address. It sits between the input-feature streamer and the PE array, and exposes every word in parallel on `infeat_buffer_o`. Depth is generalised: `NUM_WORDS` need not be a power of two.

## Interface
Parameters:
- `DATA_WIDTH`, 128: bits per word.
- `NUM_WORDS`, 64: depth; any value ≥ 2.
- `ADDR_WIDTH`, `$clog2(NUM_WORDS)`: address width.

Ports:
- `clk_i` in 1: clock; all state on the rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `clear_i` in 1: synchronous zeroing of all words.
- `re_i` in 1: read request.
- `raddr_i` in `ADDR_WIDTH`: read address.
- `rdata_o` out `DATA_WIDTH`: registered read data.
- `rvalid_o` out 1: `rdata_o` updated this cycle.
- `we_i` in 1: single-word write.
- `we_all_i` in 1: broadcast `wdata_i` to all words.
- `waddr_i` in `ADDR_WIDTH`: write address.
- `wdata_i` in `DATA_WIDTH`: write data.
- `infeat_buffer_o` out `NUM_WORDS*DATA_WIDTH`: live array contents, word 0 in the LSBs.
- `bist_start_i` in 1: start request; sampled only in IDLE.
- `bist_busy_o` out 1: engine active.
- `bist_done_o` out 1: sticky completion flag.
- `bist_fail_o` out 1: sticky mismatch flag.
- `bist_fail_addr_o` out `ADDR_WIDTH`: address of the first mismatch.

## Operation
- Reset values:
  - Array all 0; `rdata_o` 0.
  - `rvalid_o`, `bist_busy_o`, `bist_done_o`, `bist_fail_o` all 0; `bist_fail_addr_o` 0.
  - FSM in IDLE.
- Functional mode (FSM in IDLE):
  - Write priority: `clear_i` > `we_all_i` > `we_i`.
  - Writes with `waddr_i ≥ NUM_WORDS` are dropped.
  - A read with `raddr_i ≥ NUM_WORDS` returns 0.
  - Read and write to the same address in the same cycle: the read returns the old data.
  - `rdata_o` holds its value when no read is issued.
- FSM states: IDLE, M0, M1, M2, M3, M4, M5, FIN.
  - IDLE→M0 on `bist_start_i`. Entering M0 clears `bist_done_o`, `bist_fail_o` and `bist_fail_addr_o`.
  - M0, ascending: write 0.
  - M1, ascending: read expecting 0, then write 1.
  - M2, ascending: read expecting 1, then write 0.
  - M3, descending: read expecting 0, then write 1.
  - M4, descending: read expecting 1, then write 0.
  - M5, ascending: read expecting 0.
  - M5→FIN after the last address; FIN→IDLE after one cycle, setting `bist_done_o`.
  - "1" means all-ones across `DATA_WIDTH`.
- Cycle cost: each read and each write takes one cycle. Read-then-write elements spend 2 cycles per address on the same address before the address steps.
- Checking:
  - Read data is compared one cycle after the read is issued (pipelined compare). FIN exists to cover the compare for M5's last read.
  - The first mismatch sets `bist_fail_o` and latches the address of that read. Later mismatches do not update `bist_fail_addr_o`.
  - The test always runs to completion, so run time is deterministic.
- Behaviour while busy:
  - `re_i`, `we_i`, `we_all_i`, `clear_i` and `bist_start_i` are ignored.
  - `rvalid_o` stays 0 and `rdata_o` is not updated for the user.
  - `infeat_buffer_o` shows the live array contents.
- After a passing run the array is all 0.
- `bist_done_o` and `bist_fail_o` hold until the next start or reset.
- Reset asserted mid-test aborts immediately to the reset state.

## Timing
- Read latency is 1 cycle: `re_i` at cycle t gives `rdata_o` and `rvalid_o=1` at t+1. `rvalid_o` is `re_i` delayed one cycle, gated by IDLE.
- Writes become visible on `infeat_buffer_o` at t+1.
- BIST cycle budget, with N = `NUM_WORDS` and start sampled at cycle 0:
  - `bist_busy_o` is 1 from cycle 1 through cycle 10N+1 (M0…M5 take 10N cycles, FIN 1 cycle).
  - `bist_done_o` rises at cycle 10N+2, when `bist_busy_o` falls.
- `bist_start_i` held high continuously: a new test starts on the first cycle back in IDLE.

## Test plan
- Functional R/W:
  - Write `0xA5…A5` to address 3, then read address 3 → `rdata_o=0xA5…A5` and `rvalid_o=1` exactly one cycle after `re_i`.
  - Read address `NUM_WORDS` → 0.
- Priority and read-before-write:
  - Assert `clear_i`, `we_all_i` (data 0xFF…) and `we_i` together → all words 0.
  - Same-cycle read and write of address 7 → old data returned.
- Clean BIST, N=64:
  - Pulse `bist_start_i` → `bist_busy_o` high for 641 cycles, `bist_done_o=1` at cycle 642, `bist_fail_o=0`, all words 0.
  - Functional strobes during the run have no effect.
- Stuck-at fault:
  - Force bit 0 of word 5 to stuck-at-1 → `bist_fail_o=1`, `bist_fail_addr_o=5` (first failure in M1).
  - Completion time is unchanged.
- Reset mid-test:
  - Assert `rst_i` at cycle 200 of a run → all flags 0, FSM in IDLE, array 0.
  - A following start completes normally.
- Non-power-of-two depth, N=48:
  - Clean run → done at cycle 482.
  - Descending elements start at address 47.
